// File: rtl/spi_cmd_scheduler.sv
// SPI master for the probe command port. It merges a host cfg FIFO, with an
// optional trailing dummy frame, and a periodic ADC poll onto one LSB-first link.
module spi_cmd_scheduler #(
    parameter int CLK_DIV     = 5,
    parameter int FIFO_DEPTH  = 8,
    parameter int POLL_PERIOD = 1280
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_frame,
    input  logic        cfg_dummy,
    input  logic        poll_en,
    input  logic [9:0]  poll_addr,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_src,
    output logic [7:0]  poll_miss,
    output logic        busy,
    output logic        sck,
    output logic        mosi,
    output logic        cs_n,
    input  logic        miso
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(POLL_PERIOD);
    localparam logic [1:0] SRC_CFG = 2'd0, SRC_DUMMY = 2'd1, SRC_POLL = 2'd2;

    typedef enum logic [2:0] {IDLE, SHIFT_H, SHIFT_L, TAIL, GAP} state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [4:0]    bit_q;
    logic [30:0]   frame_q;
    logic [31:0]   cap_q, rd_data_q;
    logic [1:0]    cur_src_q, rd_src_q;
    logic          dummy_pend_q, last_cfg_q;
    logic          cs_n_q, sck_q, mosi_q, rd_valid_q;

    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          avail_q;
    logic [32:0]   head;
    logic          push, pop;

    logic [TW-1:0] timer_q, timer_d;
    logic          poll_pend_q, poll_pend_d;
    logic [7:0]    miss_q, miss_d;

    logic          sel_dummy, sel_poll, sel_fifo, start;
    logic [31:0]   nxt_frame;
    logic [1:0]    nxt_src;
    logic          div_last;

    assign cfg_ready = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push      = cfg_valid & cfg_ready;
    assign pop       = sel_fifo;
    assign head      = mem_q[rd_ptr_q];
    assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cfg_dummy, cfg_frame};
    end

    // avail_q lags count_q so a fresh entry costs one eligibility cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            avail_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            avail_q <= (count_q != '0);
        end
    end

    always_comb begin
        timer_d     = timer_q;
        poll_pend_d = poll_pend_q;
        miss_d      = miss_q;
        if (sel_poll) poll_pend_d = 1'b0;
        if (!poll_en) begin
            timer_d     = '0;
            poll_pend_d = 1'b0;
        end else if (timer_q == TW'(POLL_PERIOD - 1)) begin
            timer_d     = '0;
            poll_pend_d = 1'b1;
            if (poll_pend_q && !sel_poll && miss_q != 8'hFF) miss_d = miss_q + 8'd1;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= '0;
            poll_pend_q <= 1'b0;
            miss_q      <= '0;
        end else begin
            timer_q     <= timer_d;
            poll_pend_q <= poll_pend_d;
            miss_q      <= miss_d;
        end
    end

    // A pending poll jumps ahead of the FIFO only right after a cfg frame
    always_comb begin
        sel_dummy = 1'b0;
        sel_poll  = 1'b0;
        sel_fifo  = 1'b0;
        if (state_q == IDLE) begin
            if (dummy_pend_q)                     sel_dummy = 1'b1;
            else if (poll_pend_q && last_cfg_q)   sel_poll  = 1'b1;
            else if (avail_q && count_q != '0)    sel_fifo  = 1'b1;
            else if (poll_pend_q)                 sel_poll  = 1'b1;
        end
    end

    assign start     = sel_dummy | sel_poll | sel_fifo;
    assign nxt_frame = sel_fifo ? head[31:0] : sel_poll ? {6'd19, poll_addr, 16'd0} : 32'h0;
    assign nxt_src   = sel_fifo ? SRC_CFG : sel_poll ? SRC_POLL : SRC_DUMMY;
    assign div_last  = (div_q == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            frame_q      <= '0;
            cap_q        <= '0;
            cur_src_q    <= SRC_CFG;
            dummy_pend_q <= 1'b0;
            last_cfg_q   <= 1'b0;
            cs_n_q       <= 1'b1;
            sck_q        <= 1'b1;
            mosi_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_src_q     <= SRC_CFG;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q      <= SHIFT_H;
                    frame_q      <= nxt_frame[31:1];
                    cur_src_q    <= nxt_src;
                    div_q        <= '0;
                    bit_q        <= '0;
                    cs_n_q       <= 1'b0;
                    mosi_q       <= nxt_frame[0];
                    last_cfg_q   <= sel_fifo;
                    dummy_pend_q <= sel_fifo & head[32];
                end
                SHIFT_H: if (div_last) begin
                    div_q   <= '0;
                    sck_q   <= 1'b0;
                    state_q <= SHIFT_L;
                end else begin
                    div_q <= div_q + DW'(1);
                end
                SHIFT_L: begin
                    if (div_q == '0) cap_q[bit_q] <= miso;
                    if (div_last) begin
                        div_q <= '0;
                        sck_q <= 1'b1;
                        if (bit_q == 5'd31) begin
                            state_q <= TAIL;
                            mosi_q  <= 1'b0;
                        end else begin
                            // frame_q[j] holds frame bit j+1
                            mosi_q  <= frame_q[bit_q];
                            bit_q   <= bit_q + 5'd1;
                            state_q <= SHIFT_H;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                TAIL: if (div_last) begin
                    div_q      <= '0;
                    cs_n_q     <= 1'b1;
                    state_q    <= GAP;
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= cap_q;
                    rd_src_q   <= cur_src_q;
                end else begin
                    div_q <= div_q + DW'(1);
                end
                GAP: if (div_last) begin
                    div_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    div_q <= div_q + DW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cs_n      = cs_n_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_src    = rd_src_q;
    assign poll_miss = miss_q;
    assign busy      = (state_q != IDLE) || (count_q != '0) || dummy_pend_q;
endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Directed bench for spi_cmd_scheduler: framing, loopback, polling, FIFO
// backpressure with poll interleave, poll miss counting, and mid-frame reset.
`timescale 1ns/1ps
module tb_spi_cmd_scheduler;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_valid = 1'b0, cfg_dummy = 1'b0, poll_en = 1'b0, poll_en2 = 1'b0, loop = 1'b0;
    logic [31:0] cfg_frame = '0;
    logic [9:0]  poll_addr = '0;
    logic        cfg_ready, rd_valid, busy, sck, mosi, cs_n, miso;
    logic [31:0] rd_data;
    logic [1:0]  rd_src;
    logic [7:0]  poll_miss;
    logic        cfg_ready2, rd_valid2, busy2, sck2, mosi2, cs_n2;
    logic [31:0] rd_data2;
    logic [1:0]  rd_src2;
    logic [7:0]  poll_miss2;

    always #5 clk = ~clk;
    assign miso = loop & mosi;

    spi_cmd_scheduler dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_frame(cfg_frame), .cfg_dummy(cfg_dummy), .poll_en(poll_en), .poll_addr(poll_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_src(rd_src), .poll_miss(poll_miss),
        .busy(busy), .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso)
    );

    spi_cmd_scheduler #(.POLL_PERIOD(200)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(1'b0), .cfg_ready(cfg_ready2),
        .cfg_frame(32'h0), .cfg_dummy(1'b0), .poll_en(poll_en2), .poll_addr(10'h3FF),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .rd_src(rd_src2), .poll_miss(poll_miss2),
        .busy(busy2), .sck(sck2), .mosi(mosi2), .cs_n(cs_n2), .miso(1'b0)
    );

    logic [31:0] sh;
    longint      t_fall[$], t_rise[$];
    logic [31:0] words[$];
    logic [33:0] rds[$];
    logic [1:0]  exp_src [13] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2};

    always @(negedge sck) if (cs_n === 1'b0) sh = {mosi, sh[31:1]};
    always @(negedge cs_n) t_fall.push_back($time);
    always @(posedge cs_n) begin words.push_back(sh); t_rise.push_back($time); end
    always @(negedge clk) if (rd_valid === 1'b1) rds.push_back({rd_src, rd_data});

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] f, input logic d);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_frame = f; cfg_dummy = d;
        @(posedge clk);
        #1 cfg_valid = 1'b0; cfg_dummy = 1'b0;
    endtask

    task automatic wait_rds(input int n, input int budget);
        int k = 0;
        while (rds.size() < n && k < budget) begin @(posedge clk); k++; end
        chk("rd_timeout", 34'(rds.size() >= n), 34'd1);
    endtask

    task automatic wait_fall(input int n, input int budget);
        int k = 0;
        while (t_fall.size() < n && k < budget) begin @(posedge clk); k++; end
        chk("csn_timeout", 34'(t_fall.size() >= n), 34'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin @(posedge clk); k++; end
        chk("idle_timeout", 34'(busy), 34'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int rb, wb, fb, rib, q, ci;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 34'(cs_n), 34'd1);
        chk("rst_sck", 34'(sck), 34'd1);
        chk("rst_mosi", 34'(mosi), 34'd0);
        chk("rst_rd_valid", 34'(rd_valid), 34'd0);
        chk("rst_rd", {rd_src, rd_data}, 34'd0);
        chk("rst_miss", 34'(poll_miss), 34'd0);
        chk("rst_busy", 34'(busy), 34'd0);
        chk("rst_ready", 34'(cfg_ready), 34'd1);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // cfg frame with trailing dummy
        rb = rds.size(); wb = words.size(); fb = t_fall.size(); rib = t_rise.size();
        push(32'h2004_0000, 1'b1);
        chk("lat_p0", 34'(cs_n), 34'd1);
        @(posedge clk); #1 chk("lat_p1", 34'(cs_n), 34'd1);
        @(posedge clk); #1 chk("lat_p2", 34'(cs_n), 34'd0);
        wait_rds(rb + 2, 1000);
        if (rds.size() >= rb + 2 && t_rise.size() >= rib + 2) begin
            chk("dmy_word0", 34'(words[wb]), 34'h2004_0000);
            chk("dmy_word1", 34'(words[wb+1]), 34'h0);
            chk("dmy_rd0", rds[rb], {2'd0, 32'h0});
            chk("dmy_rd1", rds[rb+1], {2'd1, 32'h0});
            chk("dmy_low0", 34'((t_rise[rib] - t_fall[fb]) / 10), 34'd325);
            chk("dmy_low1", 34'((t_rise[rib+1] - t_fall[fb+1]) / 10), 34'd325);
            chk("dmy_f2f", 34'((t_fall[fb+1] - t_fall[fb]) / 10), 34'd331);
        end
        wait_idle(100);

        // loopback readback
        loop = 1'b1;
        rb = rds.size(); wb = words.size();
        push(32'h6000_55ED, 1'b0);
        wait_rds(rb + 1, 1000);
        if (rds.size() >= rb + 1) begin
            chk("lb_rd", rds[rb], {2'd0, 32'h6000_55ED});
            chk("lb_word", 34'(words[wb]), 34'h6000_55ED);
        end
        wait_idle(100);

        // periodic poll
        rb = rds.size(); wb = words.size(); fb = t_fall.size();
        @(negedge clk) poll_addr = 10'h00B; poll_en = 1'b1;
        wait_rds(rb + 2, 3500);
        if (rds.size() >= rb + 2) begin
            chk("poll_rd0", rds[rb], {2'd2, 32'h4C0B_0000});
            chk("poll_rd1", rds[rb+1], {2'd2, 32'h4C0B_0000});
            chk("poll_word", 34'(words[wb]), 34'h4C0B_0000);
            chk("poll_period", 34'((t_fall[fb+1] - t_fall[fb]) / 10), 34'd1280);
        end
        chk("poll_miss0", 34'(poll_miss), 34'd0);
        @(negedge clk) poll_en = 1'b0;
        wait_idle(500);

        // 9-deep burst behind an in-flight poll frame
        loop = 1'b0;
        rb = rds.size(); wb = words.size(); fb = t_fall.size();
        @(negedge clk) poll_en = 1'b1;
        wait_fall(fb + 1, 2000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cfg_valid = 1'b1; cfg_frame = 32'h1000_0000 + i;
            @(posedge clk);
        end
        @(negedge clk);
        chk("full_ready", 34'(cfg_ready), 34'd0);
        cfg_frame = 32'h1000_0008;
        q = 0;
        while (!cfg_ready && q < 2000) begin @(negedge clk); q++; end
        chk("ninth_held", 34'(q > 100 && q < 2000), 34'd1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        wait_rds(rb + 13, 8000);
        @(negedge clk) poll_en = 1'b0;
        if (rds.size() >= rb + 13) begin
            ci = 0;
            for (int i = 0; i < 13; i++) begin
                chk("burst_src", 34'(rds[rb+i][33:32]), 34'(exp_src[i]));
                if (exp_src[i] == 2'd2) begin
                    chk("burst_poll_word", 34'(words[wb+i]), 34'h4C0B_0000);
                end else begin
                    chk("burst_cfg_word", 34'(words[wb+i]), 34'(32'h1000_0000 + ci));
                    ci++;
                end
            end
        end
        wait_idle(1000);

        // poll miss counting with a 200-cycle period
        @(negedge clk) poll_en2 = 1'b1;
        repeat (799) @(posedge clk);
        #1 chk("miss_before1", 34'(poll_miss2), 34'd0);
        @(posedge clk);
        #1 chk("miss_first", 34'(poll_miss2), 34'd1);
        repeat (599) @(posedge clk);
        #1 chk("miss_before2", 34'(poll_miss2), 34'd1);
        @(posedge clk);
        #1 chk("miss_second", 34'(poll_miss2), 34'd2);
        @(negedge clk) poll_en2 = 1'b0;

        // reset in the middle of a frame with more frames queued
        rb = rds.size(); fb = t_fall.size();
        push(32'hA5A5_A5A5, 1'b0);
        push(32'h1111_1111, 1'b1);
        push(32'h2222_2222, 1'b0);
        wait_fall(fb + 1, 50);
        repeat (103) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("arst_cs_n", 34'(cs_n), 34'd1);
        chk("arst_sck", 34'(sck), 34'd1);
        chk("arst_busy", 34'(busy), 34'd0);
        q = rds.size();
        @(negedge clk) rst_n = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        chk("arst_no_rd", 34'(rds.size()), 34'(q));
        chk("arst_no_frame", 34'(rds.size()), 34'(rb));
        chk("arst_busy_after", 34'(busy), 34'd0);
        chk("arst_ready", 34'(cfg_ready), 34'd1);
        chk("arst_cs_n_after", 34'(cs_n), 34'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
